// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache responder.
package icache_pkg;

   localparam int WORD_W     = 32;
   localparam int LINE_W     = 128;
   localparam int ADDR_W     = 30;
   localparam int MEM_ADDR_W = 28;

   typedef enum logic {
      COMPARE,
      REFILL
   } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// One combinational read port and one synchronous write port.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8,
   parameter int INDEX_W    = $clog2(NUM_BLOCKS),
   parameter int TAG_W      = MEM_ADDR_W - INDEX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [LINE_W-1:0]  rd_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_data
);

   logic [NUM_BLOCKS-1:0] valid;
   logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
   logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

   // Only the valid bits are reset; stale tag/data is harmless while invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: zero-cycle hits, blocking
// single-line refill from memory on a miss.
module icache_responder
   import icache_pkg::*;
#(
   parameter int NUM_BLOCKS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_read,
   input  logic [ADDR_W-1:0]     proc_addr,
   output logic [WORD_W-1:0]     proc_rdata,
   output logic                  proc_stall,
   output logic                  mem_read,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0]     mem_rdata,
   input  logic                  mem_ready
);

   localparam int INDEX_W = $clog2(NUM_BLOCKS);
   localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

   state_t                  state;
   logic [MEM_ADDR_W-1:0]   miss_addr;

   logic [1:0]              offset;
   logic [INDEX_W-1:0]      index;
   logic [TAG_W-1:0]        tag;

   logic                    line_valid;
   logic [TAG_W-1:0]        line_tag;
   logic [LINE_W-1:0]       line_data;
   logic                    hit;
   logic                    wr_en;

   assign offset = proc_addr[1:0];
   assign index  = proc_addr[2 +: INDEX_W];
   assign tag    = proc_addr[ADDR_W-1 -: TAG_W];

   assign hit   = proc_read && line_valid && (line_tag == tag);
   assign wr_en = (state == REFILL) && mem_ready && !rst;

   icache_line_array #(
      .NUM_BLOCKS (NUM_BLOCKS),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) u_lines (
      .clk      (clk),
      .rst      (rst),
      .rd_index (index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (wr_en),
      .wr_index (miss_addr[INDEX_W-1:0]),
      .wr_tag   (miss_addr[MEM_ADDR_W-1 -: TAG_W]),
      .wr_data  (mem_rdata)
   );

   // The request is re-evaluated in COMPARE after every refill, so a
   // redirect during the stall simply shows up as a fresh hit or miss.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COMPARE;
         miss_addr <= '0;
      end else begin
         case (state)
            COMPARE: begin
               if (proc_read && !hit) begin
                  miss_addr <= proc_addr[ADDR_W-1:2];
                  state     <= REFILL;
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  state <= COMPARE;
               end
            end
            default: state <= COMPARE;
         endcase
      end
   end

   always_comb begin
      proc_stall = 1'b0;
      proc_rdata = '0;
      if (state == REFILL) begin
         proc_stall = 1'b1;
      end else if (hit) begin
         proc_rdata = line_data[{offset, 5'b0} +: WORD_W];
      end else begin
         proc_stall = proc_read;
      end
   end

   assign mem_read = (state == REFILL);
   assign mem_addr = mem_read ? miss_addr : '0;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios followed by
// randomized fetches, checked against a line-residency model of the cache.
module tb_icache_responder;

   localparam int NB = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         proc_read;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic [27:0]  mem_addr;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int checks   = 0;
   int failures = 0;

   // Which memory line each cache slot currently holds (-1 = empty), and the
   // line contents memory handed back for each line address.
   int           resident [NB];
   logic [127:0] backing  [int];

   always #5 clk = ~clk;

   icache_responder #(.NUM_BLOCKS(NB)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_addr  (proc_addr),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   function automatic bit model_hit(input logic [29:0] a);
      int line = int'(a[29:2]);
      return resident[line % NB] == line;
   endfunction

   function automatic logic [31:0] model_word(input logic [29:0] a);
      logic [127:0] l = backing[int'(a[29:2])];
      return l[32*int'(a[1:0]) +: 32];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) resident[i] = -1;
   endtask

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic rd, input logic [29:0] addr,
                                 input logic rdy, input logic [127:0] data);
      @(posedge clk);
      #1;
      proc_read = rd;
      proc_addr = addr;
      mem_ready = rdy;
      mem_rdata = data;
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_stall"},    proc_stall, 0);
      check_output({tag, "_rdata"},    proc_rdata, 0);
      check_output({tag, "_mem_read"}, mem_read,   0);
      check_output({tag, "_mem_addr"}, mem_addr,   0);
   endtask

   task automatic idle_cycle(input logic stray_ready);
      logic [29:0] a = 30'($urandom);
      apply_stimulus(1'b0, a, stray_ready, {$urandom, $urandom, $urandom, $urandom});
      @(negedge clk);
      check_idle("idle");
   endtask

   // One fetch: a hit is checked in its cycle; a miss is followed through its
   // refill, with mem_ready on the latency-th refill cycle. With redirect set,
   // proc_addr moves to new_addr from the second refill cycle onward.
   task automatic access(input logic [29:0] addr, input int latency,
                         input bit redirect, input logic [29:0] new_addr);
      int           line = int'(addr[29:2]);
      logic [127:0] fill;
      apply_stimulus(1'b1, addr, 1'b0, '0);
      @(negedge clk);
      if (model_hit(addr)) begin
         check_output("hit_stall",    proc_stall, 0);
         check_output("hit_rdata",    proc_rdata, 128'(model_word(addr)));
         check_output("hit_mem_read", mem_read,   0);
      end else begin
         check_output("miss_stall",    proc_stall, 1);
         check_output("miss_rdata",    proc_rdata, 0);
         check_output("miss_mem_read", mem_read,   0);
         fill = {$urandom, $urandom, $urandom, $urandom};
         for (int c = 1; c <= latency; c++) begin
            apply_stimulus(1'b1, (redirect && c >= 2) ? new_addr : addr,
                           c == latency, fill);
            @(negedge clk);
            check_output("refill_stall",    proc_stall, 1);
            check_output("refill_rdata",    proc_rdata, 0);
            check_output("refill_mem_read", mem_read,   1);
            check_output("refill_mem_addr", mem_addr,   128'(line));
         end
         backing[line]       = fill;
         resident[line % NB] = line;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [29:0] a;
      model_reset();
      rst       = 1'b1;
      proc_read = 1'b0;
      proc_addr = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");

      // Cold miss with 3-cycle memory latency, then the re-evaluated hit.
      access(30'h5, 3, 1'b0, '0);
      access(30'h5, 1, 1'b0, '0);

      // Hit streak across the whole line.
      for (int w = 4; w < 8; w++) access(30'(w), 1, 1'b0, '0);

      // Conflict on the same index, then the evicted address misses again.
      access(30'h25, 2, 1'b0, '0);
      access(30'h25, 1, 1'b0, '0);
      access(30'h5, 2, 1'b0, '0);
      access(30'h5, 1, 1'b0, '0);

      // Redirect during a refill: 0x40 completes, then 0x80 misses.
      access(30'h40, 4, 1'b1, 30'h80);
      access(30'h80, 2, 1'b0, '0);
      access(30'h80, 1, 1'b0, '0);

      // Stray mem_ready in COMPARE must not disturb anything.
      idle_cycle(1'b1);
      access(30'h80, 1, 1'b0, '0);

      // Reset in the middle of a refill.
      a = 30'h200;
      apply_stimulus(1'b1, a, 1'b0, '0);
      @(negedge clk);
      check_output("rst_miss_stall", proc_stall, 128'(!model_hit(a)));
      apply_stimulus(1'b1, a, 1'b0, '0);
      @(negedge clk);
      check_output("rst_refill_mem_read", mem_read, 1);
      apply_stimulus(1'b1, a, 1'b0, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      proc_read = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = {4{32'hDEAD_BEEF}};
      @(negedge clk);
      check_idle("after_rst");
      access(a, 2, 1'b0, '0);
      access(a, 1, 1'b0, '0);
      access(30'h5, 2, 1'b0, '0);

      // Randomized fetches over a small address pool to mix hits and conflicts.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) < 2) begin
            idle_cycle(1'($urandom_range(0, 1)));
         end else begin
            a = 30'(($urandom_range(0, 2) << 5) | ($urandom_range(0, 7) << 2)
                    | $urandom_range(0, 3));
            access(a, int'($urandom_range(1, 4)), 1'b0, '0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 The block SHALL have one parameter: NUM_BLOCKS, default 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- proc_read  in  1  fetch request valid (I_ren from fetch).
- proc_addr  in  30  word address (I_addr from fetch).
- proc_rdata  out  32  instruction word returned to fetch.
- proc_stall  out  1  request not yet served; drives fetch memory_stall.
- mem_read  out  1  line refill request to memory.
- mem_addr  out  28  line address = miss proc_addr[29:2].
- mem_rdata  in  128  refill line; word k at bits [32k+31:32k].
- mem_ready  in  1  mem_rdata valid this cycle; one-cycle pulse.

Function
REQ-004 Address split SHALL be: offset = proc_addr[1:0], index = next log2(NUM_BLOCKS) bits, tag = remaining upper bits.
REQ-005 Hit = proc_read and valid[index] and stored tag == tag.
REQ-006 FSM states SHALL be exactly COMPARE and REFILL; the reset state is COMPARE.
REQ-007 COMPARE, hit: proc_stall = 0 and proc_rdata = line word[offset], both combinational in the same cycle (zero-cycle hit latency).
REQ-008 COMPARE, proc_read = 1 and miss:
- proc_stall = 1 the same cycle.
- Latch proc_addr[29:2] into the miss-address register.
- Go to REFILL next cycle.
REQ-009 COMPARE, proc_read = 0: proc_stall = 0, proc_rdata = 0, no state change.
REQ-010 REFILL:
- mem_read = 1 and mem_addr = latched miss address, held stable until mem_ready.
- proc_stall = 1 and proc_rdata = 0.
REQ-011 REFILL, mem_ready = 1:
- Write mem_rdata, the latched tag, and valid = 1 into the latched index.
- mem_read SHALL be 0 from the next cycle.
- Return to COMPARE.
- Total miss penalty = memory latency + 1 cycle.
REQ-012 After refill, COMPARE SHALL re-evaluate the current proc_addr, so an address changed during the stall (e.g. a branch redirect) is served correctly and may miss again.
REQ-013 mem_ready while in COMPARE SHALL be ignored.
REQ-014 mem_addr SHALL be 0 whenever mem_read = 0.
REQ-015 Words SHALL pass unmodified; the fetch stage performs byte reordering and zero-to-NOP substitution.
REQ-016 A refill SHALL replace the line unconditionally: read-only cache, no dirty state, no write-back.

Reset
REQ-017 While rst = 1 at a clock edge:
- All valid bits cleared; state = COMPARE; miss-address register = 0.
- Tag and data storage need not be reset.
REQ-018 Outputs in the first cycle after reset (proc_read = 0): proc_stall = 0, proc_rdata = 0, mem_read = 0, mem_addr = 0.
REQ-019 Reset asserted during REFILL SHALL abort the refill, with mem_read = 0 the next cycle; a later mem_ready for the aborted refill SHALL be ignored.

Structure
REQ-020 Shared package icache_pkg SHALL hold:
- state enum {COMPARE, REFILL};
- localparams WORD_W = 32, LINE_W = 128, ADDR_W = 30, MEM_ADDR_W = 28.
REQ-021 Storage SHALL be one sub-module, icache_line_array, holding valid, tag and data, with one combinational read port and one synchronous write port; icache_responder holds the FSM and the hit logic.

Verification
REQ-022 Cold miss:
- Stimulus: after reset, proc_read = 1, proc_addr = 0x0000_0005.
- Response: proc_stall = 1, mem_read = 1, mem_addr = 0x000_0001.
- Memory returns mem_rdata = {D3,D2,D1,D0} with 3-cycle latency; the next cycle gives proc_stall = 0 and proc_rdata = D1.
REQ-023 Hit streak:
- Stimulus: proc_addr 0x4..0x7 on consecutive cycles after the REQ-022 refill.
- Response: zero stalls; proc_rdata = D0, D1, D2, D3.
REQ-024 Conflict:
- Stimulus: proc_addr = 0x0000_0025 (same index, different tag; NUM_BLOCKS = 8).
- Response: miss, mem_addr = 0x000_0009; then 0x5 misses again.
REQ-025 Redirect during miss:
- Stimulus: proc_addr changes from 0x40 to 0x80 mid-refill.
- Response: the refill completes for 0x40 (mem_addr 0x10), then 0x80 misses with mem_addr 0x20.
REQ-026 Reset mid-REFILL:
- Response: mem_read = 0 the next cycle; a stale mem_ready is ignored.
- A re-access to the same address misses (valid cleared).
REQ-027 proc_read = 0 with a random proc_addr: no stall, proc_rdata = 0, no mem_read.
